// File: rtl/cpu_ahb_master_if.sv
// Core-side request/response port plus AHB master bus for cpu_ahb_master.
// The master modport is the bus master's view; slave is the far side.
interface cpu_ahb_master_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_write_i;
    logic [31:0] req_addr_i;
    logic [2:0]  req_size_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic [1:0]  rsp_code_o;
    logic [31:0] HADDR_o;
    logic [1:0]  HTRANS_o;
    logic        HWRITE_o;
    logic [2:0]  HSIZE_o;
    logic [2:0]  HBURST_o;
    logic [31:0] HWDATA_o;
    logic [31:0] HRDATA_i;
    logic        HREADY_i;
    logic [1:0]  HRESP_i;

    modport master (
        input  req_valid_i, req_write_i, req_addr_i,
        input  req_size_i, req_wdata_i,
        input  HRDATA_i, HREADY_i, HRESP_i,
        output req_ready_o,
        output rsp_valid_o, rsp_rdata_o, rsp_code_o,
        output HADDR_o, HTRANS_o, HWRITE_o,
        output HSIZE_o, HBURST_o, HWDATA_o
    );

    modport slave (
        output req_valid_i, req_write_i, req_addr_i,
        output req_size_i, req_wdata_i,
        output HRDATA_i, HREADY_i, HRESP_i,
        input  req_ready_o,
        input  rsp_valid_o, rsp_rdata_o, rsp_code_o,
        input  HADDR_o, HTRANS_o, HWRITE_o,
        input  HSIZE_o, HBURST_o, HWDATA_o
    );
endinterface

// File: rtl/cpu_ahb_master.sv
// Single-outstanding AHB master: core load/store requests to AHB SINGLE
// transfers with wait states, two-cycle responses, retries and a timeout.
module cpu_ahb_master #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned MAX_RETRY      = 3
) (
    input logic              clk_i,
    input logic              rst_i,
    cpu_ahb_master_if.master bus
);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 2);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;

    localparam logic [1:0] RSP_OK     = 2'b00;
    localparam logic [1:0] RSP_BUSERR = 2'b01;
    localparam logic [1:0] RSP_ALIGN  = 2'b10;
    localparam logic [1:0] RSP_TMO    = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_RESP2,
        S_ABORT
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  size_q, size_d;
    logic        write_q, write_d;
    logic [1:0]  hresp_q, hresp_d;
    logic [2:0]  retry_q, retry_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]  rsp_code_q, rsp_code_d;

    logic          ready;
    logic          req_fire;
    logic          req_bad;
    logic [TW-1:0] tmo_inc;
    logic          tmo_hit;
    logic [2:0]    retry_inc;
    logic          retry_ok;

    assign ready    = (state_q == S_IDLE) && !rst_i;
    assign req_fire = bus.req_valid_i && ready;

    always_comb begin
        req_bad = 1'b0;
        if (bus.req_size_i > 3'd2) begin
            req_bad = 1'b1;
        end else if (bus.req_size_i == 3'd1) begin
            req_bad = bus.req_addr_i[0];
        end else if (bus.req_size_i == 3'd2) begin
            req_bad = |bus.req_addr_i[1:0];
        end
    end

    // A zero TIMEOUT_CYCLES never matches, so the counter just free-runs.
    assign tmo_inc = tmo_q + 1'b1;
    assign tmo_hit = (TIMEOUT_CYCLES != 0) &&
                     (tmo_inc == TW'(TIMEOUT_CYCLES));

    assign retry_inc = (retry_q == 3'd7) ? 3'd7 : retry_q + 3'd1;
    assign retry_ok  = 32'(retry_inc) <= MAX_RETRY;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        size_d      = size_q;
        write_d     = write_q;
        hresp_d     = hresp_q;
        retry_d     = retry_q;
        tmo_d       = tmo_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = 32'h0;
        rsp_code_d  = RSP_OK;

        unique case (state_q)
            S_IDLE: begin
                if (req_fire) begin
                    if (req_bad) begin
                        rsp_valid_d = 1'b1;
                        rsp_code_d  = RSP_ALIGN;
                    end else begin
                        addr_d  = bus.req_addr_i;
                        wdata_d = bus.req_wdata_i;
                        size_d  = bus.req_size_i;
                        write_d = bus.req_write_i;
                        retry_d = 3'd0;
                        tmo_d   = '0;
                        state_d = S_ADDR;
                    end
                end
            end
            S_ADDR: begin
                if (bus.HREADY_i) begin
                    tmo_d   = '0;
                    state_d = S_DATA;
                end else begin
                    tmo_d = tmo_inc;
                    if (tmo_hit) state_d = S_ABORT;
                end
            end
            S_DATA: begin
                if (bus.HREADY_i) begin
                    tmo_d       = '0;
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b1;
                    // HREADY high with a non-OKAY code is a slave fault.
                    if (bus.HRESP_i == HRESP_OKAY) begin
                        if (!write_q) rsp_rdata_d = bus.HRDATA_i;
                    end else begin
                        rsp_code_d = RSP_BUSERR;
                    end
                end else if (bus.HRESP_i != HRESP_OKAY) begin
                    hresp_d = bus.HRESP_i;
                    state_d = S_RESP2;
                end else begin
                    tmo_d = tmo_inc;
                    if (tmo_hit) state_d = S_ABORT;
                end
            end
            S_RESP2: begin
                if (bus.HREADY_i) begin
                    tmo_d = '0;
                    if (hresp_q == HRESP_ERROR) begin
                        state_d     = S_IDLE;
                        rsp_valid_d = 1'b1;
                        rsp_code_d  = RSP_BUSERR;
                    end else begin
                        retry_d = retry_inc;
                        if (retry_ok) begin
                            state_d = S_ADDR;
                        end else begin
                            state_d     = S_IDLE;
                            rsp_valid_d = 1'b1;
                            rsp_code_d  = RSP_BUSERR;
                        end
                    end
                end
            end
            S_ABORT: begin
                tmo_d       = '0;
                state_d     = S_IDLE;
                rsp_valid_d = 1'b1;
                rsp_code_d  = RSP_TMO;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            size_q      <= 3'd0;
            write_q     <= 1'b0;
            hresp_q     <= 2'b00;
            retry_q     <= 3'd0;
            tmo_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_code_q  <= 2'b00;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            size_q      <= size_d;
            write_q     <= write_d;
            hresp_q     <= hresp_d;
            retry_q     <= retry_d;
            tmo_q       <= tmo_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_code_q  <= rsp_code_d;
        end
    end

    assign bus.req_ready_o = ready;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_rdata_o = rsp_rdata_q;
    assign bus.rsp_code_o  = rsp_code_q;

    assign bus.HTRANS_o = (state_q == S_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign bus.HADDR_o  = addr_q;
    assign bus.HWRITE_o = write_q;
    assign bus.HSIZE_o  = size_q;
    assign bus.HBURST_o = 3'b000;
    assign bus.HWDATA_o = wdata_q;
endmodule

// File: tb/tb_cpu_ahb_master.sv
// Directed bench for cpu_ahb_master: a table of single-request scenarios
// against a scripted AHB slave, plus hand-written reset/back-to-back cases.
module tb_cpu_ahb_master;
    logic clk;
    logic rst_i;
    int   nchk;
    int   nerr;

    cpu_ahb_master_if ifc ();

    cpu_ahb_master #(
        .TIMEOUT_CYCLES(16),
        .MAX_RETRY     (3)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_i),
        .bus  (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        write;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        int          waits;
        int          nbad;
        logic [1:0]  badr;
        logic [31:0] rdata;
        logic [1:0]  e_code;
        logic [31:0] e_rdata;
        int          e_lat;
        int          e_nns;
    } vec_t;

    vec_t vt[16];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input string nm, input logic wr, input logic [31:0] a,
        input logic [2:0] sz, input logic [31:0] wd, input int w,
        input int nb, input logic [1:0] br, input logic [31:0] rd,
        input logic [1:0] ec, input logic [31:0] er, input int el,
        input int en);
        vec_t v;
        v.name = nm; v.write = wr; v.addr = a; v.size = sz;
        v.wdata = wd; v.waits = w; v.nbad = nb; v.badr = br;
        v.rdata = rd; v.e_code = ec; v.e_rdata = er;
        v.e_lat = el; v.e_nns = en;
        return v;
    endfunction

    function automatic logic all_zero();
        return ~|{ifc.req_ready_o, ifc.rsp_valid_o, ifc.rsp_rdata_o,
                  ifc.rsp_code_o, ifc.HADDR_o, ifc.HTRANS_o,
                  ifc.HWRITE_o, ifc.HSIZE_o, ifc.HBURST_o, ifc.HWDATA_o};
    endfunction

    task automatic drive_req(input logic wr, input logic [31:0] a,
                             input logic [2:0] sz, input logic [31:0] wd);
        ifc.req_valid_i = 1'b1;
        ifc.req_write_i = wr;
        ifc.req_addr_i  = a;
        ifc.req_size_i  = sz;
        ifc.req_wdata_i = wd;
    endtask

    // Runs one request; the slave reacts at each negedge to what it sees.
    task automatic run(input vec_t v);
        int          nns, wc, bad, lat;
        bit          dph, r2, ovl, got, ctl_bad, wd_bad, rdy;
        logic [1:0]  code;
        logic [31:0] rd;
        nns = 0; wc = 0; bad = v.nbad; lat = 0;
        dph = 0; r2 = 0; ovl = 0; got = 0; ctl_bad = 0; wd_bad = 0;
        rdy = 0; code = 2'b00; rd = 32'h0;
        ifc.HREADY_i = 1'b1;
        ifc.HRESP_i  = 2'b00;
        ifc.HRDATA_i = v.rdata;
        chk({v.name, ".ready"}, 32'(ifc.req_ready_o), 32'd1);
        drive_req(v.write, v.addr, v.size, v.wdata);
        for (int c = 1; c <= 60 && !got; c++) begin
            @(negedge clk);
            ifc.req_valid_i = 1'b0;
            if (ifc.HTRANS_o == 2'b10) begin
                nns++;
                if (dph || r2) ovl = 1;
                if (ifc.HADDR_o !== v.addr || ifc.HSIZE_o !== v.size ||
                    ifc.HWRITE_o !== v.write || ifc.HBURST_o !== 3'b000)
                    ctl_bad = 1;
            end else if (ifc.HTRANS_o !== 2'b00) begin
                ovl = 1;
            end
            if (ifc.rsp_valid_o) begin
                got  = 1;
                lat  = c;
                code = ifc.rsp_code_o;
                rd   = ifc.rsp_rdata_o;
                rdy  = ifc.req_ready_o;
            end else if (ifc.HTRANS_o == 2'b10) begin
                ifc.HREADY_i = 1'b1;
                ifc.HRESP_i  = 2'b00;
                dph = 1;
                wc  = 0;
            end else if (dph) begin
                if (v.write && ifc.HWDATA_o !== v.wdata) wd_bad = 1;
                if (wc < v.waits) begin
                    ifc.HREADY_i = 1'b0;
                    ifc.HRESP_i  = 2'b00;
                    wc++;
                end else if (bad > 0) begin
                    ifc.HREADY_i = 1'b0;
                    ifc.HRESP_i  = v.badr;
                    dph = 0;
                    r2  = 1;
                end else begin
                    ifc.HREADY_i = 1'b1;
                    ifc.HRESP_i  = 2'b00;
                    dph = 0;
                end
            end else if (r2) begin
                ifc.HREADY_i = 1'b1;
                ifc.HRESP_i  = v.badr;
                r2 = 0;
                bad--;
            end else begin
                ifc.HREADY_i = 1'b1;
                ifc.HRESP_i  = 2'b00;
            end
        end
        if (!got) begin
            chk({v.name, ".no_rsp"}, 32'd0, 32'd1);
        end else begin
            chk({v.name, ".code"}, 32'(code), 32'(v.e_code));
            chk({v.name, ".rdata"}, rd, v.e_rdata);
            chk({v.name, ".latency"}, 32'(lat), 32'(v.e_lat));
            chk({v.name, ".nonseq"}, 32'(nns), 32'(v.e_nns));
            chk({v.name, ".overlap"}, 32'(ovl), 32'd0);
            chk({v.name, ".ctrl"}, 32'(ctl_bad), 32'd0);
            chk({v.name, ".hwdata"}, 32'(wd_bad), 32'd0);
            chk({v.name, ".ready_at_rsp"}, 32'(rdy), 32'd1);
            ifc.HREADY_i = 1'b1;
            ifc.HRESP_i  = 2'b00;
            @(negedge clk);
            chk({v.name, ".pulse"}, 32'(ifc.rsp_valid_o), 32'd0);
        end
    endtask

    initial begin
        bit seen;
        nchk = 0;
        nerr = 0;

        vt[0]  = mk("st_b",      1, 32'h4000_0000, 0, 32'h0000_00A5,
                    0,   0, 2'b00, 32'h5555_AAAA, 0, 32'h0,        3,  1);
        vt[1]  = mk("ld_w_ws3",  0, 32'h4000_0004, 2, 32'h0,
                    3,   0, 2'b00, 32'h1234_5678, 0, 32'h1234_5678, 6, 1);
        vt[2]  = mk("ld_b",      0, 32'h4000_0003, 0, 32'h0,
                    0,   0, 2'b00, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 3, 1);
        vt[3]  = mk("st_h_ws1",  1, 32'h4000_0002, 1, 32'h0000_BEEF,
                    1,   0, 2'b00, 32'h0000_1111, 0, 32'h0,        4,  1);
        vt[4]  = mk("err",       0, 32'h4000_0008, 2, 32'h0,
                    0,   1, 2'b01, 32'h7777_7777, 1, 32'h0,        4,  1);
        vt[5]  = mk("err_ws2",   1, 32'h4000_0018, 2, 32'h0BAD_F00D,
                    2,   1, 2'b01, 32'h0,         1, 32'h0,        6,  1);
        vt[6]  = mk("retry2_a",  0, 32'h4000_000C, 2, 32'h0,
                    0,   2, 2'b10, 32'hCAFE_F00D, 0, 32'hCAFE_F00D, 9, 3);
        vt[7]  = mk("retry2_b",  0, 32'h4000_000C, 2, 32'h0,
                    0,   2, 2'b10, 32'hCAFE_F00D, 0, 32'hCAFE_F00D, 9, 3);
        vt[8]  = mk("retry3",    1, 32'h4000_0014, 2, 32'h1357_9BDF,
                    0,   3, 2'b10, 32'h0,         0, 32'h0,        12, 4);
        vt[9]  = mk("retry4",    1, 32'h4000_0014, 2, 32'h2468_ACE0,
                    0,   4, 2'b10, 32'h0,         1, 32'h0,        13, 4);
        vt[10] = mk("split1",    0, 32'h4000_0010, 1, 32'h0,
                    0,   1, 2'b11, 32'h0000_ABCD, 0, 32'h0000_ABCD, 6, 2);
        vt[11] = mk("mis_h",     0, 32'h4000_0001, 1, 32'h0,
                    0,   0, 2'b00, 32'h9999_9999, 2, 32'h0,        1,  0);
        vt[12] = mk("size3",     0, 32'h4000_0000, 3, 32'h0,
                    0,   0, 2'b00, 32'h0,         2, 32'h0,        1,  0);
        vt[13] = mk("mis_w",     1, 32'h4000_0002, 2, 32'h0,
                    0,   0, 2'b00, 32'h0,         2, 32'h0,        1,  0);
        vt[14] = mk("timeout",   1, 32'h4000_0020, 2, 32'h0000_0042,
                    100, 0, 2'b00, 32'h0,         3, 32'h0,        19, 1);
        vt[15] = mk("ws15",      0, 32'h4000_0024, 2, 32'h0,
                    15,  0, 2'b00, 32'h0F0F_0F0F, 0, 32'h0F0F_0F0F, 18, 1);

        rst_i           = 1'b1;
        ifc.req_valid_i = 1'b0;
        ifc.req_write_i = 1'b0;
        ifc.req_addr_i  = 32'h0;
        ifc.req_size_i  = 3'd0;
        ifc.req_wdata_i = 32'h0;
        ifc.HRDATA_i    = 32'h0;
        ifc.HREADY_i    = 1'b1;
        ifc.HRESP_i     = 2'b00;

        @(negedge clk);
        @(negedge clk);
        chk("reset.outputs_zero", 32'(all_zero()), 32'd1);
        rst_i = 1'b0;
        @(negedge clk);
        chk("reset.ready_after", 32'(ifc.req_ready_o), 32'd1);

        // Zero-wait store, cycle by cycle, then a back-to-back load.
        drive_req(1'b1, 32'h4000_0000, 3'd0, 32'h0000_00A5);
        @(negedge clk);
        ifc.req_valid_i = 1'b0;
        chk("seq.t1_htrans", 32'(ifc.HTRANS_o), 32'h2);
        chk("seq.t1_hwrite", 32'(ifc.HWRITE_o), 32'h1);
        chk("seq.t1_hsize", 32'(ifc.HSIZE_o), 32'h0);
        chk("seq.t1_haddr", ifc.HADDR_o, 32'h4000_0000);
        chk("seq.t1_ready", 32'(ifc.req_ready_o), 32'h0);
        @(negedge clk);
        chk("seq.t2_htrans", 32'(ifc.HTRANS_o), 32'h0);
        chk("seq.t2_hwdata", ifc.HWDATA_o, 32'h0000_00A5);
        chk("seq.t2_rsp", 32'(ifc.rsp_valid_o), 32'h0);
        @(negedge clk);
        chk("seq.t3_rsp", 32'(ifc.rsp_valid_o), 32'h1);
        chk("seq.t3_code", 32'(ifc.rsp_code_o), 32'h0);
        chk("seq.t3_ready", 32'(ifc.req_ready_o), 32'h1);
        drive_req(1'b0, 32'h4000_0040, 3'd2, 32'h0);
        ifc.HRDATA_i = 32'h1122_3344;
        @(negedge clk);
        ifc.req_valid_i = 1'b0;
        chk("b2b.t1_htrans", 32'(ifc.HTRANS_o), 32'h2);
        chk("b2b.t1_hwrite", 32'(ifc.HWRITE_o), 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("b2b.rsp", 32'(ifc.rsp_valid_o), 32'h1);
        chk("b2b.rdata", ifc.rsp_rdata_o, 32'h1122_3344);
        @(negedge clk);

        // Reset pulsed while the data phase is stalled.
        drive_req(1'b1, 32'h4000_0080, 3'd2, 32'h0000_0077);
        @(negedge clk);
        ifc.req_valid_i = 1'b0;
        @(negedge clk);
        chk("rst.in_data", 32'(ifc.HWDATA_o), 32'h0000_0077);
        ifc.HREADY_i = 1'b0;
        rst_i = 1'b1;
        @(negedge clk);
        chk("rst.outputs_zero", 32'(all_zero()), 32'd1);
        rst_i = 1'b0;
        ifc.HREADY_i = 1'b1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ifc.rsp_valid_o) seen = 1;
        end
        chk("rst.no_rsp", 32'(seen), 32'd0);
        chk("rst.ready", 32'(ifc.req_ready_o), 32'd1);

        foreach (vt[i]) run(vt[i]);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
